if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 137 +++++++++++++
 tb/tb_if_fetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC register, imem handshake, one-entry skid buffer and IF/ID register.
// Define IF_BRANCH_OFFSET_CALC_EN to form branch targets as branch_addr + (branch_imm24 << 2).
module if_fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic [23:0] branch_imm24,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] Instruction,
    output logic        inst_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    fetch_state_t state, state_n;

    logic [31:0] pc, pc_n, pc_plus4;
    logic [31:0] skid_inst, skid_inst_n;
    logic [31:0] skid_pc, skid_pc_n;
    logic [31:0] drain_addr, drain_addr_n;
    logic [31:0] inst_n, pc_out_n;
    logic        valid_n;
    logic [31:0] target_raw, target;

`ifdef IF_BRANCH_OFFSET_CALC_EN
    assign target_raw = branch_addr + {{6{branch_imm24[23]}}, branch_imm24, 2'b00};
`else
    logic unused_imm;
    assign unused_imm = ^branch_imm24;
    assign target_raw = branch_addr;
`endif

    // Targets are always word aligned.
    assign target   = {target_raw[31:2], 2'b00};
    assign pc_plus4 = pc + 32'd4;

    // While draining an abandoned request the old address must stay on the bus until it is accepted.
    assign imem_req  = rst && (state != HOLD);
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= 32'd0;
            skid_inst   <= 32'd0;
            skid_pc     <= 32'd0;
            drain_addr  <= 32'd0;
            Instruction <= 32'd0;
            pc_out      <= 32'd0;
            inst_valid  <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            skid_inst   <= skid_inst_n;
            skid_pc     <= skid_pc_n;
            drain_addr  <= drain_addr_n;
            Instruction <= inst_n;
            pc_out      <= pc_out_n;
            inst_valid  <= valid_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        skid_inst_n  = skid_inst;
        skid_pc_n    = skid_pc;
        drain_addr_n = drain_addr;
        inst_n       = Instruction;
        pc_out_n     = pc_out;
        valid_n      = inst_valid;

        if (branch_taken) begin
            // A redirect wins over freeze: flush IF/ID and the skid entry on the same edge.
            pc_n        = target;
            inst_n      = 32'd0;
            pc_out_n    = 32'd0;
            valid_n     = 1'b0;
            skid_inst_n = 32'd0;
            skid_pc_n   = 32'd0;
            unique case (state)
                FETCH: begin
                    if (!imem_ready) begin
                        state_n      = DRAIN;
                        drain_addr_n = pc;
                    end
                end
                HOLD:    state_n = FETCH;
                DRAIN:   if (imem_ready) state_n = FETCH;
                default: state_n = FETCH;
            endcase
        end else begin
            unique case (state)
                FETCH: begin
                    if (imem_ready && freeze) begin
                        skid_inst_n = imem_rdata;
                        skid_pc_n   = pc_plus4;
                        state_n     = HOLD;
                    end else if (imem_ready) begin
                        inst_n   = imem_rdata;
                        pc_out_n = pc_plus4;
                        valid_n  = 1'b1;
                        pc_n     = pc_plus4;
                    end else if (!freeze) begin
                        inst_n   = 32'd0;
                        pc_out_n = 32'd0;
                        valid_n  = 1'b0;
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        inst_n   = skid_inst;
                        pc_out_n = skid_pc;
                        valid_n  = 1'b1;
                        pc_n     = pc_plus4;
                        state_n  = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ready) state_n = FETCH;
                end
                default: state_n = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit; memory returns imem_addr XOR a pattern in the same cycle.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [23:0] branch_imm24;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] Instruction;
    logic        inst_valid;

    logic [31:0] rdata_xor;
    int          check_count;
    int          fail_count;

    localparam logic [31:0] X = 32'h5A00_0000;

    if_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .branch_imm24 (branch_imm24),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .pc_out       (pc_out),
        .Instruction  (Instruction),
        .inst_valid   (inst_valid)
    );

    assign imem_rdata = imem_addr ^ rdata_xor;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 ns after the rising edge.
    task automatic applyStimulus(input logic frz, input logic br, input logic [31:0] baddr,
                                 input logic [23:0] imm, input logic rdy);
        freeze       = frz;
        branch_taken = br;
        branch_addr  = baddr;
        branch_imm24 = imm;
        imem_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_offset_target;
        check_count  = 0;
        fail_count   = 0;
        rdata_xor    = 32'd0;
        rst          = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'd0;
        branch_imm24 = 24'd0;
        imem_ready   = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_req",   {31'd0, imem_req}, 32'd0);
        checkOutput("rst_addr",  imem_addr, 32'd0);
        checkOutput("rst_inst",  Instruction, 32'd0);
        checkOutput("rst_pcout", pc_out, 32'd0);
        checkOutput("rst_valid", {31'd0, inst_valid}, 32'd0);

        rst = 1'b1;
        #1;
        checkOutput("boot_req",  {31'd0, imem_req}, 32'd1);
        checkOutput("boot_addr", imem_addr, 32'd0);

        // Zero-wait streaming
        repeat (3) applyStimulus(1'b0, 1'b0, 32'd0, 24'd0, 1'b1);
        checkOutput("stream_inst",  Instruction, 32'h8);
        checkOutput("stream_pcout", pc_out, 32'hC);
        checkOutput("stream_valid", {31'd0, inst_valid}, 32'd1);
        checkOutput("stream_addr",  imem_addr, 32'hC);

        rdata_xor = X;
        applyStimulus(1'b0, 1'b0, 32'd0, 24'd0, 1'b1);
        checkOutput("pre_frz_inst", Instruction, 32'hC ^ X);

        // Freeze with data available: skid then release
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 24'd0, 1'b1);
            checkOutput("hold_req",   {31'd0, imem_req}, 32'd0);
            checkOutput("hold_inst",  Instruction, 32'hC ^ X);
            checkOutput("hold_pcout", pc_out, 32'h10);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 24'd0, 1'b1);
        checkOutput("unfrz_inst",  Instruction, 32'h10 ^ X);
        checkOutput("unfrz_pcout", pc_out, 32'h14);
        checkOutput("unfrz_valid", {31'd0, inst_valid}, 32'd1);
        checkOutput("unfrz_addr",  imem_addr, 32'h14);
        checkOutput("unfrz_req",   {31'd0, imem_req}, 32'd1);

        repeat (3) applyStimulus(1'b0, 1'b0, 32'd0, 24'd0, 1'b1);
        checkOutput("at20_addr", imem_addr, 32'h20);

        // Wait state loads a bubble
        applyStimulus(1'b0, 1'b0, 32'd0, 24'd0, 1'b0);
        checkOutput("wait_valid", {31'd0, inst_valid}, 32'd0);
        checkOutput("wait_inst",  Instruction, 32'd0);
        checkOutput("wait_addr",  imem_addr, 32'h20);

        // Branch during an outstanding request drains the old address
        applyStimulus(1'b0, 1'b1, 32'h100, 24'd0, 1'b0);
        checkOutput("drain_addr",  imem_addr, 32'h20);
        checkOutput("drain_req",   {31'd0, imem_req}, 32'd1);
        checkOutput("drain_valid", {31'd0, inst_valid}, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h180, 24'd0, 1'b0);
        checkOutput("drain2_addr", imem_addr, 32'h20);
        applyStimulus(1'b0, 1'b0, 32'd0, 24'd0, 1'b1);
        checkOutput("drained_addr",  imem_addr, 32'h180);
        checkOutput("drained_valid", {31'd0, inst_valid}, 32'd0);
        checkOutput("drained_inst",  Instruction, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 24'd0, 1'b1);
        checkOutput("tgt_inst",  Instruction, 32'h180 ^ X);
        checkOutput("tgt_pcout", pc_out, 32'h184);

        // Branch overrides freeze
        applyStimulus(1'b1, 1'b1, 32'h40, 24'd0, 1'b1);
        checkOutput("brfrz_valid", {31'd0, inst_valid}, 32'd0);
        checkOutput("brfrz_pcout", pc_out, 32'd0);
        checkOutput("brfrz_addr",  imem_addr, 32'h40);
        applyStimulus(1'b0, 1'b0, 32'd0, 24'd0, 1'b1);
        checkOutput("brfrz_inst", Instruction, 32'h40 ^ X);

        // Branch while holding a skid word
        applyStimulus(1'b1, 1'b0, 32'd0, 24'd0, 1'b1);
        checkOutput("skid_req", {31'd0, imem_req}, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h63, 24'd0, 1'b1);
        checkOutput("hbr_addr",  imem_addr, 32'h60);
        checkOutput("hbr_req",   {31'd0, imem_req}, 32'd1);
        checkOutput("hbr_valid", {31'd0, inst_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 24'd0, 1'b1);
        checkOutput("hbr_inst", Instruction, 32'h60 ^ X);

        // Offset target (only applied when the option is compiled in)
`ifdef IF_BRANCH_OFFSET_CALC_EN
        exp_offset_target = 32'h0000_0FF8;
`else
        exp_offset_target = 32'h0000_1000;
`endif
        applyStimulus(1'b0, 1'b1, 32'h1000, 24'hFFFFFE, 1'b1);
        checkOutput("offset_addr", imem_addr, exp_offset_target);

        // PC wraparound
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF, 24'd0, 1'b1);
        checkOutput("wrap_start", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 32'd0, 24'd0, 1'b1);
        checkOutput("wrap_inst",  Instruction, 32'hFFFF_FFFC ^ X);
        checkOutput("wrap_pcout", pc_out, 32'd0);
        checkOutput("wrap_addr",  imem_addr, 32'd0);

        // Freeze with memory stalled keeps IF/ID
        applyStimulus(1'b1, 1'b0, 32'd0, 24'd0, 1'b0);
        checkOutput("frzwait_inst",  Instruction, 32'hFFFF_FFFC ^ X);
        checkOutput("frzwait_valid", {31'd0, inst_valid}, 32'd1);
        checkOutput("frzwait_addr",  imem_addr, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 24'd0, 1'b1);
        checkOutput("post_inst", Instruction, 32'd0 ^ X);
        checkOutput("post_addr", imem_addr, 32'd4);

        // Reset in the middle of an outstanding request
        freeze     = 1'b0;
        imem_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst_req",   {31'd0, imem_req}, 32'd0);
        checkOutput("midrst_addr",  imem_addr, 32'd0);
        checkOutput("midrst_valid", {31'd0, inst_valid}, 32'd0);
        checkOutput("midrst_inst",  Instruction, 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("rerun_req",  {31'd0, imem_req}, 32'd1);
        checkOutput("rerun_addr", imem_addr, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 24'd0, 1'b1);
        checkOutput("rerun_inst",  Instruction, X);
        checkOutput("rerun_pcout", pc_out, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
